hazard_sched: RTL and testbench
===============================

HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 Parameter: DATA_WIDTH, 32, datapath width; not used internally, kept for uniform instantiation.
REQ-002 Parameter: MAX_WAIT, 255, memory-wait cycle count at which a timeout is flagged; range 1..255.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; asynchronous assertion, active-low (0 = reset).
REQ-005 Rs1D, Rs2D  in  5 each  source registers in Decode.
REQ-006 Rs1E, Rs2E, RDE  in  5 each  sources and destination in Execute.
REQ-007 ResultSrcE  in  2  result select in Execute; 2'b01 = load.
REQ-008 RDM, RDW  in  5 each  destinations in Memory and Writeback.
REQ-009 RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback.
REQ-010 MispredictE  in  1  branch/jump in Execute resolved against its prediction.
REQ-011 MemReqM, MemReadyM  in  1 each  data-memory request in Memory; memory ready/ack.
REQ-012 StallF, StallD, StallE, StallM  out  1 each  hold the PC, D/E, E/M and M/W registers (D/E enable = !StallD).
REQ-013 FlushD, FlushE, FlushW  out  1 each  sync-clear the F/D, D/E and M/W registers.
REQ-014 ForwardAE, ForwardBE  out  2 each  operand forwarding select: 00 = register file, 01 = W, 10 = M.
REQ-015 MemTimeout  out  1  sticky; memory wait reached MAX_WAIT.
REQ-016 StallCount, FlushCount  out  16 each  saturating performance counters.

Function
REQ-017 FSM states: RUN, MEM_WAIT; state register changes only on the rising clk edge or asynchronous reset.
REQ-018 ForwardAE: 10 if RegWriteM and RDM!=0 and RDM==Rs1E; else 01 if RegWriteW and RDW!=0 and RDW==Rs1E; else 00. ForwardBE uses the same rule with Rs2E. Both combinational, state-independent.
REQ-019 RUN -> MEM_WAIT when MemReqM=1 and MemReadyM=0; MEM_WAIT -> RUN on the cycle MemReadyM=1.
REQ-020 In MEM_WAIT, and in RUN on the entry cycle, StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; load-use and mispredict are ignored.
REQ-021 In RUN with no memory stall, MispredictE=1: FlushD=1 and FlushE=1 for that cycle; no stall asserted.
REQ-022 In RUN with no memory stall and no mispredict, load-use (ResultSrcE==01, RDE!=0, RDE==Rs1D or RDE==Rs2D): StallF=1, StallD=1, FlushE=1 for that cycle.
REQ-023 Priority in RUN: memory stall > mispredict > load-use > none. A mispredict concurrent with a memory stall stays held in E and is acted on the first RUN cycle after exit.
REQ-024 All unlisted outputs are 0 in every case; stall/flush outputs are combinational from state and inputs.
REQ-025 Wait counter (8-bit): cleared in RUN, incremented each MEM_WAIT cycle; MemTimeout is set when the counter equals MAX_WAIT while in MEM_WAIT, and stays set until reset; the counter saturates at MAX_WAIT.
REQ-026 StallCount increments by 1 on each cycle StallF=1; FlushCount increments by 1 on each cycle a mispredict flush (REQ-021) occurs; both hold at 16'hFFFF.
REQ-027 Reset asserted mid-MEM_WAIT immediately returns the FSM to RUN and deasserts all stalls, independent of MemReadyM.

Reset
REQ-028 While rst=0: state=RUN, wait counter=0, MemTimeout=0, StallCount=0, FlushCount=0, all stall/flush outputs 0 (inputs quiescent); the forward selects follow REQ-018.
REQ-029 First state update after rst rises occurs on the next rising clk edge.

Verification
REQ-030 Load-use: ResultSrcE=01, RDE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle, StallCount=1.
REQ-031 Forwarding: RegWriteM=1, RDM=3, RegWriteW=1, RDW=3, Rs1E=3 -> ForwardAE=10; with RDM=0 -> ForwardAE=01; with Rs1E=0 -> 00.
REQ-032 Memory miss: MemReqM=1, MemReadyM=0 for 4 cycles, then 1 -> all stalls and FlushW high for 5 cycles, RUN next cycle, StallCount=5.
REQ-033 Mispredict during wait: MispredictE=1 throughout a 3-cycle miss -> FlushD=FlushE=0 during the wait; both 1 on the first RUN cycle; FlushCount=1.
REQ-034 Timeout: MAX_WAIT=4, MemReadyM held 0 -> MemTimeout=1 after the 4th MEM_WAIT cycle and remains 1 after MemReadyM=1.
REQ-035 Async reset: rst=0 mid-MEM_WAIT, between clock edges -> stalls drop without a clk edge; counters=0; MemTimeout=0.

Source files
------------

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: operand forwarding, load-use/mispredict handling,
// memory-wait stalls with a timeout flag and saturating stall/flush counters.
module hazard_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RDE,
    input  logic [1:0]  ResultSrcE,
    input  logic [4:0]  RDM,
    input  logic [4:0]  RDW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MispredictE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemTimeout,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;
    localparam logic [7:0] MAX_W    = MAX_WAIT[7:0];

    if (DATA_WIDTH < 1 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_param
        $error("hazard_sched: parameter out of range");
    end

    logic [0:0]  state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        tout_q, tout_d;
    logic [15:0] scnt_q, scnt_d;
    logic [15:0] fcnt_q, fcnt_d;

    logic mem_stall, load_use, ms, mp_flush, lu_stall;

    // Forwarding ignores FSM state; M takes priority over W as the younger result.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && RDM != 5'd0 && RDM == Rs1E)      ForwardAE = 2'b10;
        else if (RegWriteW && RDW != 5'd0 && RDW == Rs1E) ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if (RegWriteM && RDM != 5'd0 && RDM == Rs2E)      ForwardBE = 2'b10;
        else if (RegWriteW && RDW != 5'd0 && RDW == Rs2E) ForwardBE = 2'b01;
    end

    // Stall/flush qualified by rst so an async reset drops them without a clock edge.
    assign mem_stall = (state_q == MEM_WAIT) || (MemReqM && !MemReadyM);
    assign load_use  = (ResultSrcE == 2'b01) && (RDE != 5'd0) &&
                       ((RDE == Rs1D) || (RDE == Rs2D));
    assign ms        = rst && mem_stall;
    assign mp_flush  = rst && !mem_stall && MispredictE;
    assign lu_stall  = rst && !mem_stall && !MispredictE && load_use;

    assign StallF = ms || lu_stall;
    assign StallD = ms || lu_stall;
    assign StallE = ms;
    assign StallM = ms;
    assign FlushW = ms;
    assign FlushD = mp_flush;
    assign FlushE = mp_flush || lu_stall;

    always_comb begin
        state_d = state_q;
        wcnt_d  = 8'd0;
        if (state_q == RUN) begin
            if (MemReqM && !MemReadyM) state_d = MEM_WAIT;
        end else begin
            if (MemReadyM) state_d = RUN;
            wcnt_d = (wcnt_q == MAX_W) ? wcnt_q : wcnt_q + 8'd1;
        end
        tout_d = tout_q || ((state_q == MEM_WAIT) && (wcnt_d == MAX_W));
        scnt_d = (StallF && scnt_q != 16'hFFFF) ? scnt_q + 16'd1 : scnt_q;
        fcnt_d = (mp_flush && fcnt_q != 16'hFFFF) ? fcnt_q + 16'd1 : fcnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wcnt_q  <= 8'd0;
            tout_q  <= 1'b0;
            scnt_q  <= 16'd0;
            fcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tout_q  <= tout_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign MemTimeout = tout_q;
    assign StallCount = scnt_q;
    assign FlushCount = fcnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: per-cycle expectations queued at drive
// time and compared on the falling edge.
module tb_hazard_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RDE, RDM, RDW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, MispredictE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemTimeout;
    logic [15:0] StallCount, FlushCount;

    always #5 clk = ~clk;

    hazard_sched #(.DATA_WIDTH(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RDE(RDE),
        .ResultSrcE(ResultSrcE), .RDM(RDM), .RDW(RDW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MispredictE(MispredictE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}
    localparam logic [10:0] C_NONE = 11'b0000_000_00_00;
    localparam logic [10:0] C_MEM  = 11'b1111_001_00_00;
    localparam logic [10:0] C_LU   = 11'b1100_010_00_00;
    localparam logic [10:0] C_MP   = 11'b0000_110_00_00;

    logic [10:0] ctl_obs;
    assign ctl_obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};

    typedef struct {
        string       tag;
        logic [10:0] ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        to_en;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_sc  = 0;
    int   exp_fc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".ctl"}, 32'(ctl_obs), 32'(e.ctl));
            chk({e.tag, ".scnt"}, 32'(StallCount), 32'(e.sc));
            chk({e.tag, ".fcnt"}, 32'(FlushCount), 32'(e.fc));
            if (e.to_en) chk({e.tag, ".tout"}, 32'(MemTimeout), 32'(e.to));
        end
    end

    function automatic logic [10:0] fw(input logic [1:0] a, input logic [1:0] b);
        return {7'b0, a, b};
    endfunction

    // Queue the expectation for the cycle whose inputs are now applied, then advance.
    task automatic cyc(input string tag, input logic [10:0] ctl, input logic to_en, input logic to);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.sc = exp_sc[15:0]; e.fc = exp_fc[15:0];
        e.to_en = to_en; e.to = to;
        sb.push_back(e);
        if (ctl[10]) exp_sc++;
        if (ctl[6])  exp_fc++;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RDE = 0; RDM = 0; RDW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; MispredictE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0; exp_sc = 0; exp_fc = 0;
        #1;
        chk("rst.ctl", 32'(ctl_obs), 32'(C_NONE));
        chk("rst.tout", 32'(MemTimeout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("por.ctl", 32'(ctl_obs), 32'(C_NONE));
        chk("por.scnt", 32'(StallCount), 32'd0);
        chk("por.fcnt", 32'(FlushCount), 32'd0);
        chk("por.tout", 32'(MemTimeout), 32'd0);
        RegWriteM = 1; RDM = 3; Rs1E = 3;
        #1 chk("por.fwd", 32'(ForwardAE), 32'd2);
        idle();
        rst = 1'b1;

        // forwarding
        RegWriteM = 1; RDM = 3; RegWriteW = 1; RDW = 3; Rs1E = 3;
        cyc("fwd_m", fw(2'b10, 2'b00), 1, 0);
        RDM = 0;
        cyc("fwd_w", fw(2'b01, 2'b00), 1, 0);
        RDM = 3; Rs1E = 0;
        cyc("fwd_x0", C_NONE, 1, 0);
        Rs1E = 3; Rs2E = 7; RDW = 7;
        cyc("fwd_ab", fw(2'b10, 2'b01), 1, 0);
        RegWriteM = 0; RDM = 7;
        cyc("fwd_bw", fw(2'b00, 2'b01), 1, 0);

        // load-use, mispredict and their priority
        idle(); ResultSrcE = 2'b01; RDE = 5; Rs1D = 5;
        cyc("lu_rs1", C_LU, 1, 0);
        idle();
        cyc("lu_after", C_NONE, 1, 0);
        ResultSrcE = 2'b01; RDE = 9; Rs2D = 9;
        cyc("lu_rs2", C_LU, 1, 0);
        RDE = 0; Rs2D = 0;
        cyc("lu_x0", C_NONE, 1, 0);
        ResultSrcE = 2'b10; RDE = 5; Rs1D = 5;
        cyc("lu_notld", C_NONE, 1, 0);
        ResultSrcE = 2'b01; MispredictE = 1;
        cyc("mp_over_lu", C_MP, 1, 0);
        idle(); MispredictE = 1;
        cyc("mp", C_MP, 1, 0);
        idle();
        cyc("mp_after", C_NONE, 1, 0);

        // memory miss: 4 not-ready cycles then ready
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 4; i++) cyc("miss", C_MEM, 1, 0);
        MemReadyM = 1;
        cyc("miss_rdy", C_MEM, 1, 0);
        cyc("miss_run", C_NONE, 0, 0);

        // mispredict held across a miss
        do_reset();
        MemReqM = 1; MemReadyM = 0; MispredictE = 1;
        for (int i = 0; i < 3; i++) cyc("mpw", C_MEM, 1, 0);
        MemReadyM = 1;
        cyc("mpw_rdy", C_MEM, 1, 0);
        MemReqM = 0; MemReadyM = 0;
        cyc("mpw_exit", C_MP, 1, 0);
        idle();
        cyc("mpw_done", C_NONE, 1, 0);

        // timeout at MAX_WAIT=4
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        cyc("to_entry", C_MEM, 1, 0);
        for (int i = 0; i < 4; i++) cyc("to_wait", C_MEM, 1, 0);
        cyc("to_set", C_MEM, 1, 1);
        MemReadyM = 1;
        cyc("to_rdy", C_MEM, 1, 1);
        idle();
        cyc("to_sticky", C_NONE, 1, 1);

        // async reset mid-wait with request still pending
        MemReqM = 1; MemReadyM = 0;
        cyc("ar_entry", C_MEM, 1, 1);
        cyc("ar_wait", C_MEM, 1, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar.ctl", 32'(ctl_obs), 32'(C_NONE));
        chk("ar.scnt", 32'(StallCount), 32'd0);
        chk("ar.fcnt", 32'(FlushCount), 32'd0);
        chk("ar.tout", 32'(MemTimeout), 32'd0);
        exp_sc = 0; exp_fc = 0;
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
        cyc("ar_post", C_NONE, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
